hall_call_dispatcher: RTL and testbench
=======================================

HALL_CALL_DISPATCHER -- requirements
Module: hall_call_dispatcher

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_FLOORS, 11, number of floors served (floor 0 .. NUM_FLOORS-1).
- NUM_CARS, 4, number of lift cars arbitrated.
- ACK_TIMEOUT, 15, cycles an offer waits for acknowledge before abandon.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- hall_up  input  NUM_FLOORS  per-floor up-call button level.
- hall_dn  input  NUM_FLOORS  per-floor down-call button level.
- car_floor  input  4*NUM_CARS  current floor per car; car k in bits [4k+3:4k].
- car_busy  input  NUM_CARS  1 = car k serving a job, not dispatchable.
- dispatch_ack  input  NUM_CARS  car k accepts current offer.
- dispatch_valid  output  NUM_CARS  one-hot offer to car k.
- dispatch_floor  output  4  floor of offered call.
- dispatch_dir  output  1  direction of offered call: 1 = up, 0 = down.
- pend_up  output  NUM_FLOORS  up-call lamps, pending up calls.
- pend_dn  output  NUM_FLOORS  down-call lamps, pending down calls.

Function
REQ-003 hall_up/hall_dn SHALL be edge-detected against a registered copy; a 0->1 transition sets the matching pend bit on the next clock edge; held levels never re-set a bit.
REQ-004 hall_up[NUM_FLOORS-1] and hall_dn[0] SHALL be ignored; those pend bits stay 0.
REQ-005 Call slots SHALL be indexed 0..2*NUM_FLOORS-1: slot i < NUM_FLOORS = up at floor i; otherwise down at floor i-NUM_FLOORS.
REQ-006 FSM states SHALL be IDLE, SCAN, OFFER.
- IDLE -> SCAN when any pend bit is set and any car_busy bit is 0.
REQ-007 SCAN (exactly one cycle) SHALL select the call:
- first pending slot at or after call_ptr, wrapping modulo 2*NUM_FLOORS;
- then select a non-busy car per REQ-013;
- then go to OFFER.
- If no car is free by then, return to IDLE without changing pointers.
REQ-008 In OFFER:
- dispatch_valid SHALL be one-hot on the chosen car;
- dispatch_floor and dispatch_dir SHALL be stable;
- dispatch_valid SHALL be 0 in every other state.
REQ-009 When dispatch_ack of the offered car is 1 in OFFER:
- the call's pend bit clears;
- call_ptr advances to slot+1 (wrapping);
- car_ptr advances to car+1 (wrapping);
- FSM goes to IDLE;
- dispatch_valid is 0 from the next cycle.
- Ack from a non-offered car SHALL be ignored.
REQ-010 If no ack arrives within ACK_TIMEOUT cycles of entering OFFER:
- offer is abandoned and the pend bit is kept;
- car_ptr advances past that car;
- FSM goes to IDLE.
- A 4-bit timeout counter clears on every OFFER entry.
REQ-011 A rising hall edge on the same slot in the ack cycle SHALL win: the pend bit remains set.
REQ-012 A car asserting car_busy during OFFER SHALL NOT cancel the offer; only ack or timeout ends it.

Reset
REQ-014 While rst=1, all of the following SHALL be 0 asynchronously, and the FSM SHALL be in IDLE:
- dispatch_valid, dispatch_floor, dispatch_dir;
- pend_up, pend_dn;
- call_ptr, car_ptr, timeout counter;
- edge-detect registers.
REQ-015 Reset asserted during OFFER SHALL drop dispatch_valid immediately without waiting for a clock edge; all pending calls are lost.

Configuration
REQ-013 Car selection SHALL be controlled by macro HALL_NEAREST_CAR_EN.
- Defined: choose the non-busy car minimising |car_floor - call floor|; ties go to the lowest car index.
- Undefined: choose the first non-busy car at or after car_ptr, round-robin.

Verification
REQ-016 Bench SHALL cover:
- Reset, then pulse hall_up[3]; cars 0-3 idle at floor 0. Required: pend_up[3]=1; dispatch_valid=0001, floor 3, dir 1, two cycles after the edge; ack -> pend_up[3]=0.
- hall_dn[0] and hall_up[10] pulsed. Required: pend stays 0 and dispatch_valid is never asserted.
- Offer to car 0 with no ack. Required: dispatch_valid drops after 15 cycles; pend bit stays 1; next offer of the same call goes to car 1 (macro undefined).
- HALL_NEAREST_CAR_EN defined; cars at floors 0,8,5,9 all idle; hall_dn[7] pulsed. Required: offer to car 1 (distance 1).
- hall_up[2] rises again in the cycle car acks slot 2. Required: pend_up[2] stays 1 and is re-offered.
- rst asserted mid-OFFER. Required: dispatch_valid=0 and pend_up=pend_dn=0 with no clock edge.

Source files
------------

// File: rtl/hall_call_dispatcher.sv
// Latches hall-call button edges into pending lamps and offers one call at a time to a free car.
// Define HALL_NEAREST_CAR_EN to pick the nearest free car; otherwise cars are picked round-robin.
module hall_call_dispatcher #(
  parameter int NUM_FLOORS  = 11,
  parameter int NUM_CARS    = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FLOORS-1:0]   hall_up,
  input  logic [NUM_FLOORS-1:0]   hall_dn,
  input  logic [4*NUM_CARS-1:0]   car_floor,
  input  logic [NUM_CARS-1:0]     car_busy,
  input  logic [NUM_CARS-1:0]     dispatch_ack,
  output logic [NUM_CARS-1:0]     dispatch_valid,
  output logic [3:0]              dispatch_floor,
  output logic                    dispatch_dir,
  output logic [NUM_FLOORS-1:0]   pend_up,
  output logic [NUM_FLOORS-1:0]   pend_dn
);

  localparam int NUM_SLOTS = 2 * NUM_FLOORS;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int CAR_W     = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

  // Top floor has no up button and ground floor has no down button.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SCAN, OFFER} state_t;
  state_t state, state_nxt;

  logic [NUM_FLOORS-1:0] hall_up_q, hall_dn_q;
  logic [NUM_SLOTS-1:0]  pend, rise, ack_clr;
  logic [SLOT_W-1:0]     call_ptr, offer_slot, sel_slot, scan_idx;
  logic [CAR_W-1:0]      car_ptr, offer_car, sel_car;
  logic                  slot_found, car_found;
  logic [3:0]            tmo_cnt, sel_floor;
  logic                  sel_dir, ack_hit, tmo_hit;

  assign rise    = {hall_dn & ~hall_dn_q & DN_MASK, hall_up & ~hall_up_q & UP_MASK};
  assign pend_up = pend[NUM_FLOORS-1:0];
  assign pend_dn = pend[NUM_SLOTS-1:NUM_FLOORS];

  // Handshake: dispatch_valid[k] is an offer to car k; floor/dir hold steady while it is high,
  // and the offer ends only in a cycle where dispatch_ack[k] is high or the timeout expires.
  assign ack_hit = (state == OFFER) && dispatch_ack[offer_car];
  assign tmo_hit = (state == OFFER) && (tmo_cnt == 4'(ACK_TIMEOUT - 1));
  assign ack_clr = ack_hit ? (NUM_SLOTS'(1) << offer_slot) : '0;

  // First pending slot at or after call_ptr, wrapping around the slot ring.
  always_comb begin
    sel_slot   = '0;
    slot_found = 1'b0;
    scan_idx   = '0;
    for (int off = 0; off < NUM_SLOTS; off++) begin
      if (int'(call_ptr) + off >= NUM_SLOTS) scan_idx = SLOT_W'(int'(call_ptr) + off - NUM_SLOTS);
      else                                   scan_idx = SLOT_W'(int'(call_ptr) + off);
      if (!slot_found && pend[scan_idx]) begin
        slot_found = 1'b1;
        sel_slot   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_dir   = (sel_slot < SLOT_W'(NUM_FLOORS));
    sel_floor = sel_dir ? 4'(sel_slot) : 4'(sel_slot - SLOT_W'(NUM_FLOORS));
  end

`ifdef HALL_NEAREST_CAR_EN
  logic [3:0] best_dist, dist, cf;
  // Strict less-than keeps the lowest index on equal distance.
  always_comb begin
    sel_car   = '0;
    car_found = 1'b0;
    best_dist = '0;
    dist      = '0;
    cf        = '0;
    for (int k = 0; k < NUM_CARS; k++) begin
      cf   = car_floor[4*k +: 4];
      dist = (cf > sel_floor) ? (cf - sel_floor) : (sel_floor - cf);
      if (!car_busy[k] && (!car_found || dist < best_dist)) begin
        car_found = 1'b1;
        best_dist = dist;
        sel_car   = CAR_W'(k);
      end
    end
  end
`else
  logic [CAR_W-1:0] car_idx;
  always_comb begin
    sel_car   = '0;
    car_found = 1'b0;
    car_idx   = '0;
    for (int k = 0; k < NUM_CARS; k++) begin
      if (int'(car_ptr) + k >= NUM_CARS) car_idx = CAR_W'(int'(car_ptr) + k - NUM_CARS);
      else                               car_idx = CAR_W'(int'(car_ptr) + k);
      if (!car_found && !car_busy[car_idx]) begin
        car_found = 1'b1;
        sel_car   = car_idx;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((|pend) && !(&car_busy)) state_nxt = SCAN;
      SCAN:    state_nxt = (slot_found && car_found) ? OFFER : IDLE;
      OFFER:   if (ack_hit || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dispatch_valid = '0;
    if (state == OFFER) dispatch_valid = NUM_CARS'(1) << offer_car;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_up_q      <= '0;
      hall_dn_q      <= '0;
      pend           <= '0;
      call_ptr       <= '0;
      car_ptr        <= '0;
      offer_slot     <= '0;
      offer_car      <= '0;
      tmo_cnt        <= '0;
      dispatch_floor <= '0;
      dispatch_dir   <= 1'b0;
    end else begin
      hall_up_q <= hall_up;
      hall_dn_q <= hall_dn;
      // A new button edge in the ack cycle re-arms the same slot.
      pend      <= (pend & ~ack_clr) | rise;
      if (state == SCAN && state_nxt == OFFER) begin
        offer_slot     <= sel_slot;
        offer_car      <= sel_car;
        dispatch_floor <= sel_floor;
        dispatch_dir   <= sel_dir;
        tmo_cnt        <= '0;
      end else if (state == OFFER) begin
        tmo_cnt <= tmo_cnt + 4'd1;
      end
      if (ack_hit) begin
        call_ptr <= (offer_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : offer_slot + SLOT_W'(1);
      end
      if (ack_hit || tmo_hit) begin
        car_ptr <= (offer_car == CAR_W'(NUM_CARS - 1)) ? '0 : offer_car + CAR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Bench for hall_call_dispatcher: table vectors, directed corner sequences, and random traffic
// checked against a behavioural model of the call/offer rules.
module tb_hall_call_dispatcher;

  localparam int NF   = 11;
  localparam int NC   = 4;
  localparam int TMO  = 15;
  localparam int NS   = 2 * NF;
  localparam int SB_W = NC + 4 + 1 + 2 * NF;

  logic            clk;
  logic            rst;
  logic [NF-1:0]   hall_up, hall_dn;
  logic [4*NC-1:0] car_floor;
  logic [NC-1:0]   car_busy, dispatch_ack;
  logic [NC-1:0]   dispatch_valid;
  logic [3:0]      dispatch_floor;
  logic            dispatch_dir;
  logic [NF-1:0]   pend_up, pend_dn;

  hall_call_dispatcher #(.NUM_FLOORS(NF), .NUM_CARS(NC), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .hall_up(hall_up), .hall_dn(hall_dn),
    .car_floor(car_floor), .car_busy(car_busy), .dispatch_ack(dispatch_ack),
    .dispatch_valid(dispatch_valid), .dispatch_floor(dispatch_floor),
    .dispatch_dir(dispatch_dir), .pend_up(pend_up), .pend_dn(pend_dn)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_on    = 1'b0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend[NS];
  bit m_prev_up[NF], m_prev_dn[NF];
  int m_phase;   // 0 waiting for work, 1 choosing, 2 offering
  int m_call_ptr, m_car_ptr, m_slot, m_car, m_age;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_pend[i] = 1'b0;
    for (int f = 0; f < NF; f++) begin
      m_prev_up[f] = 1'b0;
      m_prev_dn[f] = 1'b0;
    end
    m_phase = 0; m_call_ptr = 0; m_car_ptr = 0; m_slot = 0; m_car = 0; m_age = 0;
  endtask

  function automatic int pick_car(input int floor);
    int best, bd, d;
    best = -1; bd = 0;
`ifdef HALL_NEAREST_CAR_EN
    for (int c = 0; c < NC; c++) begin
      if (!car_busy[c]) begin
        d = int'(car_floor[4*c +: 4]) - floor;
        if (d < 0) d = -d;
        if (best < 0 || d < bd) begin best = c; bd = d; end
      end
    end
`else
    for (int k = 0; k < NC; k++) begin
      d = (m_car_ptr + k) % NC;
      if (best < 0 && !car_busy[d]) best = d;
    end
`endif
    return best;
  endfunction

  task automatic model_step();
    bit nxt[NS];
    bit any_pend, any_free;
    int slot, car;
    nxt = m_pend;
    any_pend = 1'b0;
    any_free = 1'b0;
    for (int i = 0; i < NS; i++) if (m_pend[i]) any_pend = 1'b1;
    for (int c = 0; c < NC; c++) if (!car_busy[c]) any_free = 1'b1;
    case (m_phase)
      0: if (any_pend && any_free) m_phase = 1;
      1: begin
        slot = -1;
        for (int off = 0; off < NS; off++)
          if (slot < 0 && m_pend[(m_call_ptr + off) % NS]) slot = (m_call_ptr + off) % NS;
        car = (slot >= 0) ? pick_car(slot % NF) : -1;
        if (slot >= 0 && car >= 0) begin
          m_slot = slot; m_car = car; m_age = 0; m_phase = 2;
        end else m_phase = 0;
      end
      default: begin
        if (dispatch_ack[m_car]) begin
          nxt[m_slot] = 1'b0;
          m_call_ptr = (m_slot + 1) % NS;
          m_car_ptr  = (m_car + 1) % NC;
          m_phase    = 0;
        end else if (m_age == TMO - 1) begin
          m_car_ptr = (m_car + 1) % NC;
          m_phase   = 0;
        end else m_age++;
      end
    endcase
    for (int f = 0; f < NF; f++) begin
      if (hall_up[f] && !m_prev_up[f] && f != NF - 1) nxt[f] = 1'b1;
      if (hall_dn[f] && !m_prev_dn[f] && f != 0) nxt[NF + f] = 1'b1;
      m_prev_up[f] = hall_up[f];
      m_prev_dn[f] = hall_dn[f];
    end
    m_pend = nxt;
  endtask

  function automatic logic [SB_W-1:0] model_expect();
    logic [NC-1:0] v;
    logic [3:0]    fl;
    logic          dr;
    logic [NF-1:0] pu, pd;
    v = '0; fl = '0; dr = 1'b0;
    if (m_phase == 2) begin
      v  = NC'(1) << m_car;
      fl = 4'(m_slot % NF);
      dr = (m_slot < NF);
    end
    for (int f = 0; f < NF; f++) begin
      pu[f] = m_pend[f];
      pd[f] = m_pend[NF + f];
    end
    return {v, fl, dr, pu, pd};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      model_step();
      if (sb_on) exp_q.push_back(model_expect());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    hall_up = '0; hall_dn = '0; car_busy = '0; dispatch_ack = '0; car_floor = '0;
    model_reset();
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_offer(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (dispatch_valid != '0) found = 1'b1;
      else tick();
    end
  endtask

  task automatic sb_compare();
    logic [SB_W-1:0] act, e;
    logic            v;
    v   = |dispatch_valid;
    act = {dispatch_valid, v ? dispatch_floor : 4'd0, v ? dispatch_dir : 1'b0, pend_up, pend_dn};
    check("sb_queue_size", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_outputs", 64'(act), 64'(e));
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int            floor;
    bit            up;
    logic [NF-1:0] exp_up;
    logic [NF-1:0] exp_dn;
    logic [NC-1:0] exp_valid;
  } vec_t;

  vec_t tbl[6];
  logic [NC-1:0] exp_second, exp_near;
  bit found;
  int cnt;

  initial begin
    rst = 1'b1;
    hall_up = '0; hall_dn = '0; car_busy = '0; dispatch_ack = '0; car_floor = '0;
`ifdef HALL_NEAREST_CAR_EN
    exp_second = 4'b0001;  // all cars at floor 0: tie goes to car 0
    exp_near   = 4'b0010;
`else
    exp_second = 4'b0010;  // round-robin moves on to car 1
    exp_near   = 4'b0001;
`endif
    tbl[0] = '{3,  1'b1, 11'h008, 11'h000, 4'b0001};
    tbl[1] = '{10, 1'b1, 11'h000, 11'h000, 4'b0000};
    tbl[2] = '{0,  1'b0, 11'h000, 11'h000, 4'b0000};
    tbl[3] = '{0,  1'b1, 11'h001, 11'h000, 4'b0001};
    tbl[4] = '{10, 1'b0, 11'h000, 11'h400, 4'b0001};
    tbl[5] = '{6,  1'b0, 11'h000, 11'h040, 4'b0001};

    apply_reset();
    check("reset_valid", 64'(dispatch_valid), 64'd0);
    check("reset_pend_up", 64'(pend_up), 64'd0);
    check("reset_pend_dn", 64'(pend_dn), 64'd0);

    for (int i = 0; i < 6; i++) begin
      apply_reset();
      if (tbl[i].up) hall_up[tbl[i].floor] = 1'b1;
      else           hall_dn[tbl[i].floor] = 1'b1;
      tick();
      hall_up = '0; hall_dn = '0;
      check($sformatf("tbl%0d_pend_up", i), 64'(pend_up), 64'(tbl[i].exp_up));
      check($sformatf("tbl%0d_pend_dn", i), 64'(pend_dn), 64'(tbl[i].exp_dn));
      tick();
      tick();
      check($sformatf("tbl%0d_valid", i), 64'(dispatch_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid != '0) begin
        check($sformatf("tbl%0d_floor", i), 64'(dispatch_floor), 64'(tbl[i].floor));
        check($sformatf("tbl%0d_dir", i), 64'(dispatch_dir), 64'(tbl[i].up));
      end
    end

    // Up call at floor 3: offer two edges after capture, ack clears the lamp.
    apply_reset();
    hall_up[3] = 1'b1;
    tick();
    hall_up = '0;
    check("up3_pend", 64'(pend_up), 64'h008);
    tick();
    check("up3_scan_no_valid", 64'(dispatch_valid), 64'd0);
    tick();
    check("up3_valid", 64'(dispatch_valid), 64'b0001);
    check("up3_floor", 64'(dispatch_floor), 64'd3);
    check("up3_dir", 64'(dispatch_dir), 64'd1);
    dispatch_ack = 4'b0001;
    tick();
    dispatch_ack = '0;
    check("up3_ack_pend", 64'(pend_up), 64'd0);
    check("up3_ack_valid", 64'(dispatch_valid), 64'd0);

    // Missing buttons never produce a call.
    apply_reset();
    hall_dn[0] = 1'b1;
    hall_up[10] = 1'b1;
    tick();
    hall_up = '0; hall_dn = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (dispatch_valid != '0) cnt++;
      tick();
    end
    check("edge_floors_valid_count", 64'(cnt), 64'd0);
    check("edge_floors_pend", 64'({pend_up, pend_dn}), 64'd0);

    // Offer times out, lamp stays, call re-offered to the next car.
    apply_reset();
    hall_up[4] = 1'b1;
    tick();
    hall_up = '0;
    tick();
    tick();
    check("tmo_first_valid", 64'(dispatch_valid), 64'b0001);
    dispatch_ack = 4'b1110;  // acks from other cars do not count
    cnt = 0;
    while (dispatch_valid != '0 && cnt < 40) begin
      cnt++;
      tick();
    end
    dispatch_ack = '0;
    check("tmo_offer_cycles", 64'(cnt), 64'd15);
    check("tmo_pend_kept", 64'(pend_up), 64'h010);
    wait_offer(10, found);
    check("tmo_reoffer_found", 64'(found), 64'd1);
    check("tmo_reoffer_car", 64'(dispatch_valid), 64'(exp_second));
    check("tmo_reoffer_floor", 64'(dispatch_floor), 64'd4);

    // Car choice with cars spread out (nearest picks car 1).
    apply_reset();
    car_floor = {4'd9, 4'd5, 4'd8, 4'd0};
    hall_dn[7] = 1'b1;
    tick();
    hall_dn = '0;
    tick();
    tick();
    check("near_valid", 64'(dispatch_valid), 64'(exp_near));
    check("near_floor", 64'(dispatch_floor), 64'd7);
    check("near_dir", 64'(dispatch_dir), 64'd0);
    car_floor = '0;

    // New press in the ack cycle keeps the lamp lit and the call is offered again.
    apply_reset();
    hall_up[2] = 1'b1;
    tick();
    hall_up = '0;
    tick();
    tick();
    check("reack_first_valid", 64'(dispatch_valid), 64'b0001);
    dispatch_ack = 4'b0001;
    hall_up[2] = 1'b1;
    tick();
    dispatch_ack = '0;
    hall_up = '0;
    check("reack_pend", 64'(pend_up), 64'h004);
    check("reack_valid_drop", 64'(dispatch_valid), 64'd0);
    wait_offer(10, found);
    check("reack_found", 64'(found), 64'd1);
    check("reack_car", 64'(dispatch_valid), 64'(exp_second));
    check("reack_floor", 64'(dispatch_floor), 64'd2);

    // Reset mid-offer clears outputs with no clock edge.
    apply_reset();
    hall_up[5] = 1'b1;
    hall_dn[7] = 1'b1;
    tick();
    hall_up = '0; hall_dn = '0;
    tick();
    tick();
    check("rst_mid_before", 64'(dispatch_valid), 64'b0001);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(dispatch_valid), 64'd0);
    check("rst_mid_pend_up", 64'(pend_up), 64'd0);
    check("rst_mid_pend_dn", 64'(pend_dn), 64'd0);
    check("rst_mid_floor", 64'({dispatch_floor, dispatch_dir}), 64'd0);

    // Random traffic against the model.
    apply_reset();
    sb_on = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      hall_up      = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '0;
      hall_dn      = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '0;
      car_busy     = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
      dispatch_ack = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
      if ($urandom_range(0, 15) == 0)
        for (int c = 0; c < NC; c++) car_floor[4*c +: 4] = 4'($urandom_range(0, NF - 1));
      tick();
      sb_compare();
    end
    sb_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
